// File: rtl/fetch_pc_redirect.sv
// Front-end PC generator and in-order instruction fetch sequencer.
// The PC issues fetch requests, tags each one with its address, and buffers
// the returned words for decode. A redirect from the jump/branch unit reloads
// the PC, squashes buffered and in-flight fetches, and traps misaligned targets.
module fetch_pc_redirect #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush,
  output logic        misalign_exc
);

  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  // Squashed responses can pile up across several redirects while a slow
  // imem drains, so the drop counter is wider than the in-flight limit.
  localparam int DROP_W = 8;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  entry_t               buf_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [CNT_W-1:0]     buf_cnt_q, buf_cnt_d;
  logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                 flush_q, flush_d;
  logic                 misalign_q, misalign_d;

  logic                 req_hs;
  logic                 rsp_accept;
  logic                 rsp_drop;
  logic                 pop;
  logic [CNT_W:0]       occupancy;
  entry_t               head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request, response and decode handshakes; a redirect overrides all of them.
  always_comb begin
    occupancy      = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};
    imem_req_valid = (state_q == ST_RUN) && !redir_valid &&
                     (occupancy < (CNT_W + 1)'(MAX_OUTSTANDING));
    imem_req_addr  = pc_q;
    req_hs         = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_accept     = imem_rsp_valid && (drop_cnt_q == '0) && !redir_valid;
    instr_valid    = (buf_cnt_q != '0);
    pop            = instr_valid && !stall && !redir_valid;
    head           = buf_mem[buf_rd_q];
    // NOTE: the buffer storage is never reset, so the head is masked while
    // the buffer is empty to keep stale words off the decode interface.
    instr          = instr_valid ? head.data : '0;
    instr_pc       = instr_valid ? head.pc   : '0;
    flush          = flush_q;
    misalign_exc   = misalign_q;
  end

  // Next-state logic for the PC, sequencer state, queues and counters.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    out_cnt_d  = out_cnt_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;
    drop_cnt_d = drop_cnt_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    if (redir_valid) begin
      // Everything younger than the redirect is squashed; in-flight
      // responses are dropped on arrival, including one landing right now.
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      out_cnt_d  = '0;
      buf_wr_d   = '0;
      buf_rd_d   = '0;
      buf_cnt_d  = '0;
      drop_cnt_d = drop_cnt_q + DROP_W'(out_cnt_q);
      if (imem_rsp_valid && (drop_cnt_d != '0)) begin
        drop_cnt_d = drop_cnt_d - DROP_W'(1);
      end
      flush_d = 1'b1;
      if (redir_pc[1:0] == 2'b00) begin
        pc_d    = redir_pc;
        state_d = ST_RUN;
      end else begin
        misalign_d = 1'b1;
        state_d    = ST_HALT;
      end
    end else begin
      if (state_q == ST_BOOT) begin
        state_d = ST_RUN;
      end
      if (req_hs) begin
        pc_d     = pc_q + 32'd4;
        tag_wr_d = ptr_inc(tag_wr_q);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
      if (rsp_accept) begin
        tag_rd_d = ptr_inc(tag_rd_q);
        buf_wr_d = ptr_inc(buf_wr_q);
      end
      if (pop) begin
        buf_rd_d = ptr_inc(buf_rd_q);
      end
      out_cnt_d = out_cnt_q + CNT_W'(req_hs) - CNT_W'(rsp_accept);
      buf_cnt_d = buf_cnt_q + CNT_W'(rsp_accept) - CNT_W'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      out_cnt_q  <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      buf_cnt_q  <= '0;
      drop_cnt_q <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      out_cnt_q  <= out_cnt_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_cnt_q  <= buf_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  // Tag queue and instruction buffer storage; validity lives in the pointers.
  always_ff @(posedge clk) begin
    if (req_hs) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (rsp_accept) begin
      buf_mem[buf_wr_q] <= '{pc: tag_mem[tag_rd_q], data: imem_rsp_data};
    end
  end

endmodule
